pwm_peripheral: RTL and testbench

Register-mapped 16-channel PWM generator that sits directly downstream of the SPI receive stage. It takes validated 8-bit register writes (address 0x00–0x04) and holds the output-enable, PWM-enable and duty registers. It drives 16 registered output pins, each either static or PWM-modulated. All channels share one 8-bit duty cycle, applied glitch-free at period boundaries.

---
 rtl/pwm_peripheral.sv | 153 +++++++++++++++
 tb/tb_pwm_peripheral.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16-channel register-mapped PWM generator fed by the SPI
// receive stage.
//
// Parameters
//   PRESCALE : clk cycles per PWM counter step (>= 1)
//   MAX_ADDR : highest register address that is accepted
//
// Ports
//   clk         : system clock, rising edge
//   rst         : synchronous reset, active-high
//   wr_valid    : one-cycle write strobe
//   wr_addr     : register address (valid with wr_valid)
//   wr_data     : register data (valid with wr_valid)
//   wr_err      : one-cycle pulse after a write above MAX_ADDR
//   period_tick : one-cycle pulse when the PWM counter wraps to 0
//   pwm_out     : registered channel pins
//
// Register map
//   0x00 en_out[7:0]   0x01 en_out[15:8]
//   0x02 en_pwm[7:0]   0x03 en_pwm[15:8]
//   0x04 duty_pending  (copied to duty_active at each period boundary)
module pwm_peripheral #(
  parameter int unsigned PRESCALE = 3000,
  parameter int unsigned MAX_ADDR = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  input  logic [6:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_err,
  output logic        period_tick,
  output logic [15:0] pwm_out
);

  localparam int unsigned CH_N    = 16;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
  localparam logic [DATA_W-1:0]  CNT_LAST   = DATA_W'(255);
  localparam logic [DATA_W-1:0]  DUTY_FULL  = DATA_W'(255);

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] ADDR_DUTY      = ADDR_W'(4);

  logic [PRESC_W-1:0] presc;
  logic [DATA_W-1:0]  cnt;
  logic [CH_N-1:0]    en_out;
  logic [CH_N-1:0]    en_pwm;
  logic [DATA_W-1:0]  duty_pending;
  logic [DATA_W-1:0]  duty_active;

  logic              addr_ok_c;
  logic              wr_ok_c;
  logic              wr_en_out_lo_c;
  logic              wr_en_out_hi_c;
  logic              wr_en_pwm_lo_c;
  logic              wr_en_pwm_hi_c;
  logic              wr_duty_c;
  logic              presc_wrap_c;
  logic              boundary_c;
  logic              pwm_hi_c;
  logic [CH_N-1:0]   level_c;

  // Write decode; addresses in range but without a register are accepted as no-ops.
  always_comb begin
    addr_ok_c      = (32'(wr_addr) <= MAX_ADDR);
    wr_ok_c        = wr_valid && addr_ok_c;
    wr_en_out_lo_c = 1'b0;
    wr_en_out_hi_c = 1'b0;
    wr_en_pwm_lo_c = 1'b0;
    wr_en_pwm_hi_c = 1'b0;
    wr_duty_c      = 1'b0;
    if (wr_ok_c) begin
      wr_en_out_lo_c = (wr_addr == ADDR_EN_OUT_LO);
      wr_en_out_hi_c = (wr_addr == ADDR_EN_OUT_HI);
      wr_en_pwm_lo_c = (wr_addr == ADDR_EN_PWM_LO);
      wr_en_pwm_hi_c = (wr_addr == ADDR_EN_PWM_HI);
      wr_duty_c      = (wr_addr == ADDR_DUTY);
    end
  end

  // Period timing: the boundary is the last prescaler step of count 255.
  always_comb begin
    presc_wrap_c = (presc == PRESC_LAST);
    boundary_c   = presc_wrap_c && (cnt == CNT_LAST);
  end

  // Channel level from the current count; full duty is forced high so that
  // 0xFF has no low step at cnt==255.
  always_comb begin
    pwm_hi_c = (duty_active == DUTY_FULL) || (cnt < duty_active);
    level_c  = en_out & (~en_pwm | {CH_N{pwm_hi_c}});
  end

  // Prescaler and PWM counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      cnt   <= '0;
    end else begin
      if (presc_wrap_c) begin
        presc <= '0;
        cnt   <= cnt + DATA_W'(1);
      end else begin
        presc <= presc + PRESC_W'(1);
      end
    end
  end

  // Enable registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_out <= '0;
      en_pwm <= '0;
    end else begin
      if (wr_en_out_lo_c) en_out[7:0]  <= wr_data;
      if (wr_en_out_hi_c) en_out[15:8] <= wr_data;
      if (wr_en_pwm_lo_c) en_pwm[7:0]  <= wr_data;
      if (wr_en_pwm_hi_c) en_pwm[15:8] <= wr_data;
    end
  end

  // Duty staging; a duty write landing on the boundary goes straight to active.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_pending <= '0;
      duty_active  <= '0;
    end else begin
      if (wr_duty_c) duty_pending <= wr_data;
      if (boundary_c) duty_active <= wr_duty_c ? wr_data : duty_pending;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out     <= '0;
      wr_err      <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      pwm_out     <= level_c;
      wr_err      <= wr_valid && !addr_ok_c;
      period_tick <= boundary_c;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench for pwm_peripheral with PRESCALE=2 (512-cycle period).
// Stimulus pushes expectations into three queues: per-cycle pin snapshots,
// wr_err pulse cycles, and per-period high-time profiles. One negedge monitor
// pops and compares them as the DUT produces the corresponding output.
module tb_pwm_peripheral;

  localparam int unsigned PRESCALE = 2;
  localparam int unsigned MAX_ADDR = 4;
  localparam int          PERIOD   = 256 * PRESCALE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [6:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_err;
  logic        period_tick;
  logic [15:0] pwm_out;

  pwm_peripheral #(
    .PRESCALE(PRESCALE),
    .MAX_ADDR(MAX_ADDR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_err     (wr_err),
    .period_tick(period_tick),
    .pwm_out    (pwm_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] pwm;
    bit          chk_pulse;
  } snap_t;

  // Expected high-cycle count per bit for one period window:
  // hi_mask bits -> PERIOD, pwm_mask bits -> pwm_hi, others -> 0.
  typedef struct {
    int          tick_no;
    int          exp_cyc;
    logic [15:0] hi_mask;
    logic [15:0] pwm_mask;
    int          pwm_hi;
  } win_t;

  snap_t snap_q[$];
  win_t  win_q[$];
  int    err_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  int tick_no  = 0;
  int nsamp    = 0;
  int hi_cnt[16];
  bit skip_one = 1'b0;

  // Monitor: snapshots, error pulses, and period windows.
  always @(negedge clk) begin : mon
    snap_t s;
    win_t  w;
    int    exp_i;
    int    bad;
    bit    ok;

    while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
      s = snap_q.pop_front();
      n_cmp++;
      if (s.cyc != cyc) begin
        n_fail++;
        $display("FAIL snapshot missed: due cycle %0d, now cycle %0d", s.cyc, cyc);
      end else if (pwm_out !== s.pwm ||
                   (s.chk_pulse && (period_tick !== 1'b0 || wr_err !== 1'b0))) begin
        n_fail++;
        $display("FAIL snapshot cyc=%0d: pwm_out=%h tick=%b err=%b, want pwm_out=%h%s",
                 cyc, pwm_out, period_tick, wr_err, s.pwm,
                 s.chk_pulse ? " tick=0 err=0" : "");
      end
    end

    while (err_q.size() > 0 && err_q[0] < cyc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wr_err missing: want pulse at cycle %0d, got none", err_q.pop_front());
    end
    if (wr_err !== 1'b0) begin
      n_cmp++;
      if (wr_err === 1'b1 && err_q.size() > 0 && err_q[0] == cyc) begin
        void'(err_q.pop_front());
      end else begin
        n_fail++;
        $display("FAIL wr_err unexpected: wr_err=%b at cycle %0d, want 0", wr_err, cyc);
      end
    end

    if (rst) begin
      nsamp    = 0;
      tick_no  = 0;
      skip_one = 1'b1;
      for (int i = 0; i < 16; i++) hi_cnt[i] = 0;
    end else if (skip_one) begin
      skip_one = 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) hi_cnt[i] += int'(pwm_out[i] === 1'b1);
      nsamp++;
      if (period_tick === 1'b1) begin
        tick_no++;
        while (win_q.size() > 0 && win_q[0].tick_no < tick_no) begin
          w = win_q.pop_front();
          n_cmp++;
          n_fail++;
          $display("FAIL window %0d never checked (now window %0d)", w.tick_no, tick_no);
        end
        if (win_q.size() > 0 && win_q[0].tick_no == tick_no) begin
          w  = win_q.pop_front();
          ok = (nsamp == PERIOD) && (w.exp_cyc < 0 || w.exp_cyc == cyc);
          bad = 0;
          for (int i = 15; i >= 0; i--) begin
            exp_i = w.hi_mask[i] ? PERIOD : (w.pwm_mask[i] ? w.pwm_hi : 0);
            if (hi_cnt[i] != exp_i) begin
              ok  = 1'b0;
              bad = i;
            end
          end
          exp_i = w.hi_mask[bad] ? PERIOD : (w.pwm_mask[bad] ? w.pwm_hi : 0);
          n_cmp++;
          if (!ok) begin
            n_fail++;
            $display("FAIL window %0d: len=%0d tick_cyc=%0d bit%0d high=%0d, want len=%0d tick_cyc=%0d high=%0d",
                     tick_no, nsamp, cyc, bad, hi_cnt[bad], PERIOD, w.exp_cyc, exp_i);
          end
        end
        nsamp = 0;
        for (int i = 0; i < 16; i++) hi_cnt[i] = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_tick();
    bit got;
    got = 1'b0;
    for (int i = 0; i < PERIOD + 16 && !got; i++) begin
      step();
      if (period_tick === 1'b1) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_tick: no period_tick within %0d cycles (cycle %0d)", PERIOD + 16, cyc);
    end
  endtask

  task automatic push_snap(input int c, input logic [15:0] p, input bit chk);
    snap_t s;
    s.cyc       = c;
    s.pwm       = p;
    s.chk_pulse = chk;
    snap_q.push_back(s);
  endtask

  task automatic push_win(input int t, input int ec, input logic [15:0] hm,
                          input logic [15:0] pm, input int ph);
    win_t w;
    w.tick_no  = t;
    w.exp_cyc  = ec;
    w.hi_mask  = hm;
    w.pwm_mask = pm;
    w.pwm_hi   = ph;
    win_q.push_back(w);
  endtask

  // Let the pending registers take effect at the next boundary, then expect
  // n full periods with the given profile.
  task automatic expect_windows(input int n, input logic [15:0] hm,
                                input logic [15:0] pm, input int ph);
    wait_tick();
    for (int j = 0; j < n; j++) push_win(tick_no + 2 + j, -1, hm, pm, ph);
    repeat (n) wait_tick();
  endtask

  initial begin : stim
    int c0;
    int rel;

    // Power-on reset; first tick 512 cycles after release.
    repeat (3) step();
    rst = 1'b0;
    rel = cyc;
    push_snap(rel, 16'h0000, 1'b1);
    push_win(1, rel + PERIOD, 16'h0000, 16'h0000, 0);
    wait_tick();

    // Static outputs with 2-cycle strobe-to-pin latency.
    c0 = cyc;
    push_snap(c0 + 1, 16'h0000, 1'b1);
    push_snap(c0 + 2, 16'h00A5, 1'b1);
    push_snap(c0 + 3, 16'h3CA5, 1'b1);
    wr(7'h00, 8'hA5);
    wr(7'h01, 8'h3C);
    expect_windows(2, 16'h3CA5, 16'h0000, 0);

    // All channels PWM: duty 0x80, then 0x00, then 0xFF.
    wr(7'h02, 8'hFF);
    wr(7'h03, 8'hFF);
    wr(7'h00, 8'hFF);
    wr(7'h01, 8'hFF);
    wr(7'h04, 8'h80);
    expect_windows(1, 16'h0000, 16'hFFFF, 256);
    wr(7'h04, 8'h00);
    expect_windows(1, 16'h0000, 16'hFFFF, 0);
    wr(7'h04, 8'hFF);
    expect_windows(1, 16'h0000, 16'hFFFF, PERIOD);

    // Mixed enables with duty 0x40.
    wr(7'h00, 8'hFF);
    wr(7'h01, 8'h00);
    wr(7'h02, 8'h0F);
    wr(7'h03, 8'h00);
    wr(7'h04, 8'h40);
    expect_windows(1, 16'h00F0, 16'h000F, 128);

    // Mid-period duty change 0x80 -> 0x20 waits for the boundary.
    wr(7'h00, 8'hFF);
    wr(7'h01, 8'hFF);
    wr(7'h02, 8'hFF);
    wr(7'h03, 8'hFF);
    wr(7'h04, 8'h80);
    wait_tick();
    repeat (200) step();
    push_win(tick_no + 1, -1, 16'h0000, 16'hFFFF, 256);
    push_win(tick_no + 2, -1, 16'h0000, 16'hFFFF, 64);
    wr(7'h04, 8'h20);
    wait_tick();
    wait_tick();

    // Duty write sampled exactly on the boundary edge is used immediately.
    repeat (PERIOD - 1) step();
    push_win(tick_no + 1, -1, 16'h0000, 16'hFFFF, 64);
    push_win(tick_no + 2, -1, 16'h0000, 16'hFFFF, 32);
    wr(7'h04, 8'h10);
    wait_tick();

    // Out-of-range writes: one wr_err pulse each, no register change.
    c0 = cyc;
    err_q.push_back(c0 + 1);
    wr(7'h05, 8'h00);
    step();
    c0 = cyc;
    err_q.push_back(c0 + 1);
    wr(7'h7F, 8'h00);
    expect_windows(1, 16'h0000, 16'hFFFF, 32);

    // Reset mid-operation with everything at 0xFF, write during reset ignored.
    wr(7'h00, 8'hFF);
    wr(7'h01, 8'hFF);
    wr(7'h02, 8'hFF);
    wr(7'h03, 8'hFF);
    wr(7'h04, 8'hFF);
    wait_tick();
    repeat (50) step();
    c0 = cyc;
    push_snap(c0, 16'hFFFF, 1'b0);
    push_snap(c0 + 1, 16'h0000, 1'b1);
    rst = 1'b1;
    step();
    step();
    wr_valid = 1'b1;
    wr_addr  = 7'h00;
    wr_data  = 8'hFF;
    step();
    wr_valid = 1'b0;
    rst      = 1'b0;
    rel      = cyc;
    push_snap(rel, 16'h0000, 1'b1);
    push_win(1, rel + PERIOD, 16'h0000, 16'h0000, 0);
    wait_tick();

    repeat (4) step();
    n_cmp++;
    if (snap_q.size() + win_q.size() + err_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d snapshots, %0d windows, %0d errors left, want 0",
               snap_q.size(), win_q.size(), err_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
